// File: rtl/wb_management_bridge.sv
// Wishbone classic slave that turns host bus cycles into single-cycle
// read/write strobes on the core management port. The management block
// arbitrates this bridge against JTAG; while JTAG owns the bus (busy) the
// strobe is held and retried, up to a bounded number of cycles, after which
// the host gets err instead of ack.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wb_sel_i, wb_adr_i         byte select, byte address ([23:20] selects bridge)
//   wb_data_i / wb_data_o      write data in / read data out
//   wb_ack_o, wb_err_o         transfer acknowledge / timeout error
//   wb_management_*            management strobes, select, address, data, busy
module wb_management_bridge #(
  parameter logic [3:0] BASE_ADDRESS   = 4'h3,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_data_o,
  output logic        wb_management_writeEnable,
  output logic        wb_management_readEnable,
  output logic [3:0]  wb_management_byteSelect,
  output logic [19:0] wb_management_address,
  output logic [31:0] wb_management_writeData,
  input  logic [31:0] wb_management_readData,
  input  logic        wb_management_busy
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    REQUEST      = 3'd1,
    ACK          = 3'd2,
    ERROR        = 3'd3,
    WAIT_RELEASE = 3'd4
  } bridgeState_t;

  bridgeState_t state;
  bridgeState_t nextState;

  logic        weQ;
  logic [3:0]  selQ;
  logic [19:0] adrQ;
  logic [31:0] dataQ;
  logic [31:0] rdataQ;
  logic [7:0]  retryCount;

  logic hit;
  logic timeoutHit;

  assign hit = wb_cyc_i & wb_stb_i & (wb_adr_i[23:20] == BASE_ADDRESS);

  // Compared against the count before this cycle's increment, so the bridge
  // retries TIMEOUT_CYCLES times and times out on the following busy cycle.
  assign timeoutHit = (TIMEOUT_CYCLES != 8'd0) && (retryCount == TIMEOUT_CYCLES);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; host abort outranks both accept and timeout
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (hit) nextState = REQUEST;
      end
      REQUEST: begin
        if (!wb_cyc_i) begin
          nextState = IDLE;
        end else if (!wb_management_busy) begin
          nextState = ACK;
        end else if (timeoutHit) begin
          nextState = ERROR;
        end
      end
      ACK:          nextState = WAIT_RELEASE;
      ERROR:        nextState = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (!wb_stb_i || !wb_cyc_i) nextState = IDLE;
      end
      default:      nextState = IDLE;
    endcase
  end

  // Holding registers, read-data capture and saturating retry counter
  always_ff @(posedge clk) begin
    if (rst) begin
      weQ        <= 1'b0;
      selQ       <= 4'h0;
      adrQ       <= 20'h0;
      dataQ      <= 32'h0;
      rdataQ     <= 32'h0;
      retryCount <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          retryCount <= 8'h0;
          if (hit) begin
            weQ   <= wb_we_i;
            selQ  <= wb_sel_i;
            adrQ  <= wb_adr_i[19:0];
            dataQ <= wb_data_i;
          end
        end
        REQUEST: begin
          if (wb_cyc_i) begin
            if (!wb_management_busy) begin
              rdataQ <= weQ ? 32'h0 : wb_management_readData;
            end else if (retryCount != 8'hFF) begin
              retryCount <= retryCount + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; everything is zero outside its owning state
  always_comb begin
    wb_ack_o                  = 1'b0;
    wb_err_o                  = 1'b0;
    wb_data_o                 = 32'h0;
    wb_management_writeEnable = 1'b0;
    wb_management_readEnable  = 1'b0;
    wb_management_byteSelect  = 4'h0;
    wb_management_address     = 20'h0;
    wb_management_writeData   = 32'h0;
    case (state)
      REQUEST: begin
        wb_management_writeEnable = weQ;
        wb_management_readEnable  = ~weQ;
        wb_management_byteSelect  = selQ;
        wb_management_address     = adrQ;
        wb_management_writeData   = weQ ? dataQ : 32'h0;
      end
      ACK: begin
        wb_ack_o  = 1'b1;
        wb_data_o = rdataQ;
      end
      ERROR: begin
        wb_err_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_management_bridge.sv
// Self-checking bench for wb_management_bridge. Each transaction is planned
// up front: from the hit cycle, busy length, abort/reset point and timeout
// the bench writes the expected outputs of every affected cycle into a
// table keyed by cycle number; unlisted cycles must be all-zero.
module tb_wb_management_bridge;

  localparam logic [3:0] BASE = 4'h3;
  localparam int         TMO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [23:0] wb_adr_i;
  logic [31:0] wb_data_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_data_o;
  logic        mWe, mRe;
  logic [3:0]  mSel;
  logic [19:0] mAdr;
  logic [31:0] mWdata, mRdata;
  logic        mBusy;

  always #5 clk = ~clk;

  wb_management_bridge #(.BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(8'd4)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_data_o(wb_data_o),
    .wb_management_writeEnable(mWe), .wb_management_readEnable(mRe),
    .wb_management_byteSelect(mSel), .wb_management_address(mAdr),
    .wb_management_writeData(mWdata), .wb_management_readData(mRdata),
    .wb_management_busy(mBusy)
  );

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        re;
    logic        we;
    logic [3:0]  sel;
    logic [19:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } outT;

  outT expOut [int];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  bit  checkEn = 1'b0;

  int          lastAckCycle, lastErrCycle, strobeCycles;
  logic [31:0] lastAckData, lastWdata;
  logic [19:0] lastAdr;

  // Per-cycle compare against the planned table
  always @(negedge clk) begin : cmp
    outT act;
    outT exp;
    if (checkEn) begin
      act = {wb_ack_o, wb_err_o, mRe, mWe, mSel, mAdr, mWdata, wb_data_o};
      exp = expOut.exists(cyc) ? expOut[cyc] : '0;
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs cycle %0d: actual=%h required=%h", cyc, act, exp);
      end
      checks++;
      if (wb_ack_o && wb_err_o) begin
        errors++;
        $display("FAIL ack_err_exclusive cycle %0d: actual=both required=at most one", cyc);
      end
      checks++;
      if (mRe && mWe) begin
        errors++;
        $display("FAIL strobe_exclusive cycle %0d: actual=both required=at most one", cyc);
      end
      if (wb_ack_o) begin
        lastAckCycle = cyc;
        lastAckData  = wb_data_o;
      end
      if (wb_err_o) lastErrCycle = cyc;
      if (mRe || mWe) begin
        strobeCycles++;
        lastAdr   = mAdr;
        lastWdata = mWdata;
      end
    end
  end

  task automatic pin(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Bus idle: never cyc and stb together, everything else random
  task automatic setIdle();
    int mode;
    mode      = int'($urandom_range(0, 2));
    wb_cyc_i  = (mode == 1);
    wb_stb_i  = (mode == 2);
    wb_we_i   = 1'($urandom);
    wb_sel_i  = 4'($urandom);
    wb_adr_i  = ($urandom_range(0, 1) == 0) ? {BASE, 20'($urandom)} : 24'($urandom);
    wb_data_i = $urandom;
    mBusy     = 1'($urandom);
    mRdata    = $urandom;
  endtask

  task automatic clearMon();
    lastAckCycle = -1;
    lastErrCycle = -1;
    strobeCycles = 0;
  endtask

  // One host transaction; abortAt/rstAt index the REQUEST cycle (-1 = none)
  task automatic runXfer(input bit we, input logic [23:0] adr, input logic [3:0] sel,
                         input logic [31:0] data, input logic [31:0] rdVal,
                         input int busyLen, input int abortAt, input int rstAt,
                         input int hold, output int hitCycle);
    int  reqLen, last, j;
    bit  hit, tmo, term;
    tick();
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_adr_i  = adr;
    wb_sel_i  = sel;
    wb_data_i = data;
    mBusy     = 1'($urandom);
    mRdata    = $urandom;
    hitCycle  = cyc;
    hit    = (adr[23:20] == BASE);
    tmo    = (busyLen > TMO);
    reqLen = tmo ? TMO + 1 : busyLen + 1;
    term   = 1'b1;
    if (abortAt >= 0 && abortAt < reqLen) begin reqLen = abortAt + 1; term = 1'b0; end
    if (rstAt >= 0 && rstAt < reqLen)     begin reqLen = rstAt + 1;   term = 1'b0; end
    if (hit) begin
      for (int i = 0; i < reqLen; i++)
        expOut[hitCycle + 1 + i] = {1'b0, 1'b0, !we, we, sel, adr[19:0],
                                    (we ? data : 32'h0), 32'h0};
      if (term) begin
        if (tmo) expOut[hitCycle + 1 + reqLen] = {1'b0, 1'b1, 90'h0};
        else     expOut[hitCycle + 1 + reqLen] = {1'b1, 1'b0, 58'h0, (we ? 32'h0 : rdVal)};
      end
      last = term ? reqLen + hold : reqLen - 1;
    end else begin
      last = 2 + hold;
    end
    for (int k = 0; k <= last; k++) begin
      tick();
      j = cyc - hitCycle - 1;
      // Held request inputs scrambled: the bridge must use its latched copy
      wb_data_i      = $urandom;
      wb_sel_i       = 4'($urandom);
      wb_adr_i[19:0] = 20'($urandom);
      mBusy  = (j < busyLen);
      mRdata = (j == busyLen) ? rdVal : $urandom;
      if (hit && j == abortAt) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        break;
      end
      if (hit && j == rstAt) begin
        rst      = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        break;
      end
    end
    tick();
    rst = 1'b0;
    setIdle();
  endtask

  initial begin
    int n, busyLen, abortAt, rstAt, r;
    bit we;
    logic [23:0] adr;
    logic [31:0] rd;
    rst = 1'b1;
    setIdle();
    clearMon();
    tick();
    checkEn = 1'b1;
    tick();
    rst = 1'b0;
    setIdle();
    tick();

    // Plain write
    clearMon();
    runXfer(1'b1, 24'h300000, 4'hF, 32'h1, 32'h0, 0, -1, -1, 1, n);
    pin("write_ack_latency", lastAckCycle - n, 2);
    pin("write_ack_data", int'(lastAckData), 0);
    pin("write_strobe_cycles", strobeCycles, 1);
    pin("write_address", int'(lastAdr), 0);
    pin("write_data", int'(lastWdata), 1);

    // Plain read
    clearMon();
    runXfer(1'b0, 24'h300004, 4'hF, 32'hDEADBEEF, 32'h13, 0, -1, -1, 0, n);
    pin("read_ack_latency", lastAckCycle - n, 2);
    pin("read_ack_data", int'(lastAckData), 32'h13);
    pin("read_strobe_cycles", strobeCycles, 1);
    pin("read_address", int'(lastAdr), 4);

    // Read with 3 busy cycles
    clearMon();
    runXfer(1'b0, 24'h300008, 4'h3, 32'h0, 32'hA5A5_0001, 3, -1, -1, 2, n);
    pin("busy3_ack_latency", lastAckCycle - n, 5);
    pin("busy3_strobe_cycles", strobeCycles, 4);

    // Busy forever: timeout after 4 retries
    clearMon();
    runXfer(1'b0, 24'h30000C, 4'hF, 32'h0, 32'h77, 100, -1, -1, 2, n);
    pin("timeout_err_latency", lastErrCycle - n, 6);
    pin("timeout_no_ack", lastAckCycle, -1);
    pin("timeout_strobe_cycles", strobeCycles, 5);

    // Address miss
    clearMon();
    runXfer(1'b1, 24'h100000, 4'hF, 32'h55, 32'h0, 0, -1, -1, 1, n);
    pin("miss_strobe_cycles", strobeCycles, 0);
    pin("miss_no_ack", lastAckCycle, -1);
    pin("miss_no_err", lastErrCycle, -1);

    // Host abort while busy, and abort racing an accept
    clearMon();
    runXfer(1'b0, 24'h300010, 4'hF, 32'h0, 32'h9, 10, 2, -1, 0, n);
    pin("abort_busy_strobe_cycles", strobeCycles, 3);
    pin("abort_busy_no_ack", lastAckCycle, -1);
    clearMon();
    runXfer(1'b1, 24'h300014, 4'hF, 32'h9, 32'h0, 0, 0, -1, 0, n);
    pin("abort_accept_strobe_cycles", strobeCycles, 1);
    pin("abort_accept_no_ack", lastAckCycle, -1);

    // Reset in REQUEST, then a normal transfer
    clearMon();
    runXfer(1'b0, 24'h300018, 4'hF, 32'h0, 32'h9, 10, -1, 1, 0, n);
    pin("reset_strobe_cycles", strobeCycles, 2);
    pin("reset_no_ack", lastAckCycle, -1);
    clearMon();
    runXfer(1'b1, 24'h30001C, 4'h5, 32'hCAFE_F00D, 32'h0, 0, -1, -1, 0, n);
    pin("after_reset_ack_latency", lastAckCycle - n, 2);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      r       = int'($urandom_range(0, 2));
      for (int g = 0; g < r; g++) tick();
      we      = 1'($urandom);
      adr     = ($urandom_range(0, 9) < 8) ? {BASE, 20'($urandom)} : 24'($urandom);
      rd      = $urandom;
      busyLen = int'($urandom_range(0, 6));
      abortAt = -1;
      rstAt   = -1;
      r       = int'($urandom_range(0, 19));
      if (r < 2)      abortAt = int'($urandom_range(0, (busyLen < TMO) ? busyLen : TMO));
      else if (r < 3) rstAt   = int'($urandom_range(0, (busyLen < TMO) ? busyLen : TMO));
      runXfer(we, adr, 4'($urandom), $urandom, rd, busyLen, abortAt, rstAt,
              int'($urandom_range(0, 2)), n);
    end

    tick();
    tick();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_management_bridge.md
Name: wb_management_bridge

Overview:
- Wishbone classic slave that converts host bus cycles into single-cycle read/write strobes on the core management port (wb_management_*).
- Sits directly upstream of the core management block, which arbitrates between this bridge and JTAG.
- Handles JTAG contention through the management busy flag, using retry with a bounded timeout.
- Returns ack, or err on timeout, to the Wishbone host.

Parameters:
- BASE_ADDRESS, 4'h3: value of wb_adr_i[23:20] that selects this bridge.
- TIMEOUT_CYCLES, 8'd255: maximum number of busy retry cycles before the bridge signals an error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  Wishbone write enable
- wb_sel_i  in  4  Wishbone byte select
- wb_adr_i  in  24  Wishbone byte address
- wb_data_i  in  32  Wishbone write data
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  transfer error (timeout)
- wb_data_o  out  32  read data
- wb_management_writeEnable  out  1  management write strobe
- wb_management_readEnable  out  1  management read strobe
- wb_management_byteSelect  out  4  management byte select
- wb_management_address  out  20  management byte address (wb_adr_i[19:0])
- wb_management_writeData  out  32  management write data
- wb_management_readData  in  32  management read data, valid combinationally while a strobe is high and busy is low
- wb_management_busy  in  1  JTAG currently owns the management bus

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: all outputs 0, state IDLE, retry counter 0.
- Address match: hit = wb_cyc_i & wb_stb_i & (wb_adr_i[23:20] == BASE_ADDRESS). On a miss the bridge never drives ack or err.
- State IDLE:
  - On hit, latch we, sel, adr[19:0] and data_i into holding registers.
  - Clear the retry counter.
  - Go to REQUEST.
- State REQUEST:
  - Drive readEnable = !we_q and writeEnable = we_q.
  - Drive byteSelect, address and writeData from the holding registers.
  - Write data is driven as 0 on reads.
- REQUEST, busy = 0 (accept): the strobe was consumed this cycle.
  - Register wb_management_readData into rdata_q on reads; rdata_q = 0 on writes.
  - Go to ACK.
- REQUEST, busy = 1:
  - Stay in REQUEST with strobes held and increment the retry counter.
  - If the counter == TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0, go to ERROR instead.
- REQUEST, wb_cyc_i = 0 (host abort): return to IDLE with no ack or err. Abort takes priority over accept in the same cycle.
- State ACK:
  - wb_ack_o = 1 for exactly one cycle.
  - wb_data_o = rdata_q.
  - Next state is WAIT_RELEASE.
- State ERROR:
  - wb_err_o = 1 for exactly one cycle.
  - wb_data_o = 0.
  - Next state is WAIT_RELEASE.
- State WAIT_RELEASE: return to IDLE once wb_stb_i = 0 or wb_cyc_i = 0. This prevents a held strobe from issuing a duplicate transfer.
- Strobe outputs are high only in REQUEST and are deasserted in every other state.
- Latency with no contention, measured from the hit cycle N:
  - Strobe high in cycle N+1.
  - Ack in cycle N+2.
  - Each busy cycle adds 1.
- Exclusivity:
  - ack and err are never high together.
  - readEnable and writeEnable are never high together.
- Retry counter: 8 bits and saturating; it never wraps.
- Reset mid-operation returns to IDLE with all outputs 0 on the next edge. No ack is produced for the interrupted cycle.

Test Plan:
- Write 0x00000001 to adr 0x300000, sel 4'hF, busy = 0:
  - writeEnable high for exactly 1 cycle with address 0x00000 and data 0x00000001.
  - ack 2 cycles after the hit.
  - wb_data_o = 0.
- Read adr 0x300004 with readData = 0x00000013:
  - readEnable high for 1 cycle.
  - wb_data_o = 0x00000013 with ack in cycle N+2.
- Busy held high for 3 cycles during a read:
  - Strobe stays high for 4 cycles.
  - Address is stable throughout.
  - Ack arrives in cycle N+5.
- Busy held permanently high, TIMEOUT_CYCLES = 4:
  - err is high for 1 cycle after 4 retries.
  - ack is never asserted and strobes drop.
- Access to adr 0x100000 (miss):
  - No strobe, ack or err in any cycle.
- Abort and reset:
  - Drop wb_cyc_i while busy is high: strobes drop next cycle, no ack, bridge back in IDLE.
  - Assert rst while in REQUEST: all outputs 0 on the next edge.
  - The next hit still completes normally.
